// File: rtl/mux_chain_eval.sv
// mux_chain_eval: bit-serial generate/propagate carry chain.
// An accepted operand set is evaluated one lane per cycle (lane 0 first); the
// result is held with out_valid until the consumer takes it.
// Optional feature: define MUX_CHAIN_EVAL_PARITY_EN to add the 'parity' output
// (XOR of all sum bits and cout).
module mux_chain_eval #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] d,
    input  logic [LANES-1:0] s,
    input  logic             g_hi,
    input  logic             g_lo,
    input  logic             p_hi,
    input  logic             p_lo,
    input  logic             cin_n,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] sum,
    output logic             cout
`ifdef MUX_CHAIN_EVAL_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Index width stays >= 1 so LANES=1 still has a legal register.
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [LANES-1:0] r_d;
    logic [LANES-1:0] r_s;
    logic             r_g_hi;
    logic             r_g_lo;
    logic             r_p_hi;
    logic             r_p_lo;
    logic             r_carry;
    logic [LANES-1:0] r_sum;
    logic             r_cout;

    logic             w_d_bit;
    logic             w_s_bit;
    logic             w_gen;
    logic             w_prop;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [LANES-1:0] w_sum_nxt;

    // Evaluate the lane selected by r_idx and merge its sum bit into the sum vector.
    always_comb begin
        w_d_bit = 1'b0;
        w_s_bit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(r_idx) == i) begin
                w_d_bit = r_d[i];
                w_s_bit = r_s[i];
            end
        end
        w_gen       = ~w_s_bit & (w_d_bit ? r_g_hi : r_g_lo);
        w_prop      = w_s_bit & (w_d_bit ? r_p_hi : r_p_lo);
        w_sum_bit   = w_gen ^ w_prop ^ r_carry;
        w_carry_nxt = w_gen | (w_prop & r_carry);
        w_sum_nxt   = r_sum;
        for (int i = 0; i < LANES; i++) begin
            if (int'(r_idx) == i) begin
                w_sum_nxt[i] = w_sum_bit;
            end
        end
    end

    // Control FSM and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_d     <= d;
                        r_s     <= s;
                        r_g_hi  <= g_hi;
                        r_g_lo  <= g_lo;
                        r_p_hi  <= p_hi;
                        r_p_lo  <= p_lo;
                        // Carry register starts as c_0.
                        r_carry <= en & ~cin_n;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_carry_nxt;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_carry_nxt;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifdef MUX_CHAIN_EVAL_PARITY_EN
    // Sum and cout are both cleared by reset, so parity reads 0 after reset.
    assign parity = (^r_sum) ^ r_cout;
`endif

endmodule

// File: tb/tb_mux_chain_eval.sv
// Bench for mux_chain_eval: three instances (LANES = 4, 1, 32) share the operand
// buses; a behavioural model predicts handshake timing and results each cycle.
module tb_mux_chain_eval;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [31:0] d;
    logic [31:0] s;
    logic        g_hi, g_lo, p_hi, p_lo, cin_n, en;
    logic [3:0]  sum4;
    logic [0:0]  sum1;
    logic [31:0] sum32;
    logic [2:0]  cout;
    logic [2:0]  par;
    logic [31:0] sum_x [3];

    int total = 0;
    int bad   = 0;

    int lanes_of [3] = '{4, 1, 32};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_chain_eval #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .d(d[3:0]), .s(s[3:0]), .g_hi(g_hi), .g_lo(g_lo), .p_hi(p_hi), .p_lo(p_lo),
        .cin_n(cin_n), .en(en), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum4), .cout(cout[0])
`ifdef MUX_CHAIN_EVAL_PARITY_EN
        , .parity(par[0])
`endif
    );

    mux_chain_eval #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .d(d[0:0]), .s(s[0:0]), .g_hi(g_hi), .g_lo(g_lo), .p_hi(p_hi), .p_lo(p_lo),
        .cin_n(cin_n), .en(en), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum1), .cout(cout[1])
`ifdef MUX_CHAIN_EVAL_PARITY_EN
        , .parity(par[1])
`endif
    );

    mux_chain_eval #(.LANES(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .d(d), .s(s), .g_hi(g_hi), .g_lo(g_lo), .p_hi(p_hi), .p_lo(p_lo),
        .cin_n(cin_n), .en(en), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum32), .cout(cout[2])
`ifdef MUX_CHAIN_EVAL_PARITY_EN
        , .parity(par[2])
`endif
    );

`ifndef MUX_CHAIN_EVAL_PARITY_EN
    assign par = 3'b000;
`endif

    always_comb begin
        sum_x[0] = {28'b0, sum4};
        sum_x[1] = {31'b0, sum1};
        sum_x[2] = sum32;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    // Reference result straight from the lane equations.
    function automatic void ref_eval(input int n, input logic [31:0] dd, input logic [31:0] ss,
                                     input logic [5:0] ctl, output logic [31:0] sm,
                                     output logic co);
        logic ghi, glo, phi, plo, cn, e, c, g, p;
        {ghi, glo, phi, plo, cn, e} = ctl;
        c  = e & ~cn;
        sm = '0;
        for (int i = 0; i < n; i++) begin
            g     = ~ss[i] & (dd[i] ? ghi : glo);
            p     = ss[i] & (dd[i] ? phi : plo);
            sm[i] = g ^ p ^ c;
            c     = g | (p & c);
        end
        co = c;
    endfunction

    // Model state per instance: 0 idle, 1 busy, 2 holding a result.
    int          m_st  [3] = '{0, 0, 0};
    int          m_cnt [3] = '{0, 0, 0};
    logic [31:0] m_sum [3];
    logic        m_cout[3];
    logic        seen_rst = 1'b0;

    // Compare outputs to the model, then advance the model to the next edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (seen_rst) begin
                chk("in_ready", k, in_ready[k], m_st[k] == 0);
                chk("out_valid", k, out_valid[k], m_st[k] == 2);
                if (m_st[k] == 2) begin
                    chk("sum", k, sum_x[k], m_sum[k]);
                    chk("cout", k, cout[k], m_cout[k]);
`ifdef MUX_CHAIN_EVAL_PARITY_EN
                    chk("parity", k, par[k], (^m_sum[k]) ^ m_cout[k]);
`endif
                end
            end
            if (!rst_n) begin
                m_st[k] = 0;
            end else if (m_st[k] == 0) begin
                if (in_valid[k]) begin
                    ref_eval(lanes_of[k], d, s, {g_hi, g_lo, p_hi, p_lo, cin_n, en},
                             m_sum[k], m_cout[k]);
                    m_st[k]  = 1;
                    m_cnt[k] = 0;
                end
            end else if (m_st[k] == 1) begin
                m_cnt[k]++;
                if (m_cnt[k] == lanes_of[k]) m_st[k] = 2;
            end else if (out_ready[k]) begin
                m_st[k] = 0;
            end
        end
        if (!rst_n) seen_rst = 1'b1;
    end

    task automatic scramble();
        d = $urandom;
        s = $urandom;
        {g_hi, g_lo, p_hi, p_lo, cin_n, en} = 6'($urandom);
    endtask

    // One operation on instance k. mode 0: random out_ready, 1: always ready,
    // 2: hold out_ready low for 10 result cycles. Called and returns at posedge+1.
    task automatic do_op(input int k, input logic [31:0] dd, input logic [31:0] ss,
                         input logic [5:0] ctl, input int mode,
                         output logic [31:0] gs, output logic gc, output logic gp);
        logic accepted, done, seen;
        int   hold;
        accepted = 1'b0;
        done     = 1'b0;
        seen     = 1'b0;
        hold     = 0;
        gs       = '0;
        gc       = 1'b0;
        gp       = 1'b0;
        d = dd;
        s = ss;
        {g_hi, g_lo, p_hi, p_lo, cin_n, en} = ctl;
        in_valid[k] = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready[k]) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        chk("accept_timeout", k, accepted, 1'b1);
        for (int t = 0; t < 400 && !done && accepted; t++) begin
            if (mode == 1)      out_ready[k] = 1'b1;
            else if (mode == 2) out_ready[k] = (hold >= 10);
            else                out_ready[k] = 1'($urandom_range(0, 1));
            scramble();
            @(negedge clk);
            if (out_valid[k]) begin
                if (!seen) begin
                    gs   = sum_x[k];
                    gc   = cout[k];
                    gp   = par[k];
                    seen = 1'b1;
                end
                if (mode == 2 && hold < 10) begin
                    chk("bp_in_ready", k, in_ready[k], 1'b0);
                    chk("bp_sum", k, sum_x[k], gs);
                    chk("bp_cout", k, cout[k], gc);
                    hold++;
                end
                if (out_ready[k]) done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_ready[k] = 1'b0;
        chk("done_timeout", k, done, 1'b1);
    endtask

    initial begin
        logic [31:0] gs;
        logic        gc, gp;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Propagate chain: every lane propagates, c_0 = 1.
        do_op(0, 32'h0, 32'hF, 6'b000101, 1, gs, gc, gp);
        chk("prop_sum", 0, gs, 32'h0);
        chk("prop_cout", 0, gc, 1'b1);
`ifdef MUX_CHAIN_EVAL_PARITY_EN
        chk("prop_parity", 0, gp, 1'b1);
`endif

        // Generate chain, carry-in disabled: lane 0 sums 1, the rest see carry 1.
        do_op(0, 32'hF, 32'h0, 6'b100000, 0, gs, gc, gp);
        chk("gen_sum", 0, gs, 32'h1);
        chk("gen_cout", 0, gc, 1'b1);

        // Generate chain with carry-in 1: every lane sums 0.
        do_op(0, 32'hF, 32'h0, 6'b100001, 0, gs, gc, gp);
        chk("genc_sum", 0, gs, 32'h0);
        chk("genc_cout", 0, gc, 1'b1);

        // Backpressure then release.
        do_op(0, 32'h5, 32'hA, 6'b110110, 2, gs, gc, gp);
        @(negedge clk);
        chk("bp_release_valid", 0, out_valid[0], 1'b0);
        chk("bp_release_ready", 0, in_ready[0], 1'b1);
        @(posedge clk);
        #1;

        // Reset after lane 1 has been evaluated, with in_valid raised during reset.
        d = 32'h0;
        s = 32'hF;
        {g_hi, g_lo, p_hi, p_lo, cin_n, en} = 6'b000101;
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_pre_ready", 0, in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 0, out_valid[0], 1'b0);
        chk("rst_sum", 0, sum_x[0], 32'h0);
        chk("rst_cout", 0, cout[0], 1'b0);
        chk("rst_in_ready", 0, in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        do_op(0, 32'h0, 32'hF, 6'b000101, 0, gs, gc, gp);
        chk("post_rst_sum", 0, gs, 32'h0);
        chk("post_rst_cout", 0, gc, 1'b1);

        // Randomized operations; results checked by the model process.
        for (int n = 0; n < 200; n++) begin
            do_op(0, $urandom, $urandom, 6'($urandom), int'($urandom_range(0, 1)), gs, gc, gp);
        end
        for (int n = 0; n < 1000; n++) begin
            do_op(1, $urandom, $urandom, 6'($urandom), int'($urandom_range(0, 1)), gs, gc, gp);
        end
        for (int n = 0; n < 1000; n++) begin
            do_op(2, $urandom, $urandom, 6'($urandom), int'($urandom_range(0, 1)), gs, gc, gp);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
